// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 returned in place of a real word on any fetch error
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } err_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        err_e            err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// rtl/imem_responder_resp_fifo.sv - synchronous response FIFO with flush and registered full/empty
module resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 66
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Qualify push/pop against full/empty and compute the next fill level
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    // Pointer and status registers; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage is not reset; stale slots are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    assign pop_data = store[rd_ptr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory with fixed-latency in-order fetch responses
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic [1:0]                     rsp_err,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int CAP = LATENCY + 2;
    localparam int CW  = $clog2(CAP + 1);
    localparam int RW  = $bits(imem_rsp_t);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   offset;
    logic          misaligned;
    logic          out_of_range;
    logic          accept;
    logic          in_valid;
    imem_rsp_t     in_rsp;
    logic          push;
    imem_rsp_t     push_rsp;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occupancy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [RW-1:0] head_bits;
    imem_rsp_t     head;

    // Side load port; the read below sees the pre-write word at the same edge
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Decode the fetch address, classify errors and read the word
    always_comb begin
        offset       = req_addr - BASE_ADDR;
        misaligned   = (offset[1:0] != 2'b00);
        out_of_range = (req_addr < BASE_ADDR) || (offset[31:2] >= 30'(DEPTH_WORDS));
        in_rsp.addr  = req_addr;
        in_rsp.instr = NOP;
        in_rsp.err   = ERR_OK;
        if (misaligned) begin
            in_rsp.err = ERR_MISALIGN;
        end else if (out_of_range) begin
            in_rsp.err = ERR_RANGE;
        end else begin
            in_rsp.instr = mem[offset[AW+1:2]];
        end
    end

    // Occupancy counts every accepted entry not yet popped, so the FIFO can never overflow
    assign occupancy = inflight + fifo_count;
    assign req_ready = !reset && !fifo_full && (occupancy < CW'(CAP));
    assign accept    = req_valid && req_ready;
    assign in_valid  = accept && !flush;

    generate
        if (LATENCY == 1) begin : g_direct
            assign push     = in_valid;
            assign push_rsp = in_rsp;
            assign inflight = '0;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_valid;
            imem_rsp_t          pipe_rsp [LATENCY-1];

            // Valid bits of the read pipeline, cleared by reset or flush
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= in_valid;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // Payload of the read pipeline; only meaningful where the valid bit is set
            always_ff @(posedge clk) begin
                pipe_rsp[0] <= in_rsp;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_rsp[i] <= pipe_rsp[i-1];
                end
            end

            assign push     = pipe_valid[LATENCY-2];
            assign push_rsp = pipe_rsp[LATENCY-2];
            assign inflight = CW'($countones(pipe_valid));
        end
    endgenerate

    resp_fifo #(
        .DEPTH (CAP),
        .WIDTH (RW)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_rsp),
        .pop       (rsp_ready && !fifo_empty),
        .pop_data  (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs read zero whenever nothing is buffered, including after reset
    assign head      = imem_rsp_t'(head_bits);
    assign rsp_valid = !fifo_empty;
    assign rsp_instr = fifo_empty ? '0 : head.instr;
    assign rsp_addr  = fifo_empty ? '0 : head.addr;
    assign rsp_err   = fifo_empty ? ERR_OK : head.err;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the MYTH RISC-V core: the consumer end of the program-counter address stream. It accepts fetch requests (word address from the PC/fetch logic) over a valid/ready handshake and returns the 32-bit instruction at that address after a fixed read latency, in request order, through a small output FIFO. Misaligned and out-of-range fetches return a NOP plus an error code instead of stalling. A side load port fills the memory before or during execution.

## Interface
Parameters:
- DEPTH_WORDS, 256: memory size in 32-bit words (power of two, 16..4096).
- LATENCY, 1: read pipeline depth in cycles (1..4).
- BASE_ADDR, 32'h0000_0000: byte address of word 0 (word-aligned).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the fetch (PC value).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_instr  out  32  instruction word.
- rsp_addr  out  32  echo of the request address.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- flush  in  1  discard all in-flight and buffered responses (branch redirect).
- load_en  in  1  write one memory word.
- load_addr  in  $clog2(DEPTH_WORDS)  word index for load.
- load_data  in  32  word to write.

## Operation
- Request accepted on a rising edge where req_valid && req_ready.
- Word index = (req_addr - BASE_ADDR) >> 2, computed on 32 bits, no wrap.
- Error check: req_addr[1:0] != 0 gives err 01; else req_addr < BASE_ADDR or index >= DEPTH_WORDS gives err 10. Misaligned takes precedence. Any error: rsp_instr = 32'h0000_0013 (NOP), no memory read.
- Occupancy = in-flight pipeline entries + FIFO entries. FIFO depth = LATENCY+2. req_ready = !reset && occupancy < LATENCY+2. req_ready depends on registered state only, never on rsp_ready or req_valid.
- Responses leave in acceptance order. While rsp_valid && !rsp_ready, rsp_instr/rsp_addr/rsp_err hold stable.
- Load port: write at the edge where load_en=1. A fetch of the same word accepted at the same edge returns the old word (read-before-write). Load is independent of handshakes, flush and errors.
- flush=1 at an edge: all pipeline and FIFO entries invalidated; a request accepted at that same edge is also discarded. Occupancy 0 and req_ready=1 in the next cycle; rsp_valid=0 in the next cycle.
- reset=1 at an edge: same clearing as flush. Memory contents are not cleared.

## Timing
- Reset values: req_ready=0 while reset is high, 1 in the first cycle after; rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=00.
- Latency: request accepted at the end of cycle k with an empty FIFO gives rsp_valid=1 in cycle k+LATENCY.
- Throughput: one response per cycle sustained with req_valid and rsp_ready held high, for every LATENCY.
- Backpressure: with rsp_ready=0, exactly LATENCY+2 requests are accepted, then req_ready=0 until a pop. A pop at an edge raises req_ready in the next cycle.
- Reset or flush mid-stream: no response from before the edge ever appears afterward.

## Structure
- Package imem_pkg holds: NOP constant 32'h0000_0013, error codes ERR_OK/ERR_MISALIGN/ERR_RANGE, XLEN=32, and a response struct/typedef of {instr, addr, err}.
- One sub-module: resp_fifo, a synchronous FIFO parameterised by depth and width, with a flush input, count output, and registered full/empty.
- Top level holds the memory array, address decode/error logic, LATENCY-stage valid/tag pipeline and occupancy counter.

## Test plan
- Load words 0..3 = 32'h11111111..32'h44444444; fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1, LATENCY=2 -> responses in order, first rsp_valid 2 cycles after the first acceptance, one per cycle, err=00.
- Fetch 0x2 and 0x400 (DEPTH_WORDS=256) -> instr 32'h00000013, err 01 and 10. Fetch 0x402 -> err 01.
- rsp_ready=0 with req_valid held, LATENCY=1 -> exactly 3 accepts, then req_ready=0. Drain one -> req_ready=1 the next cycle. Held rsp_* stable throughout.
- 3 requests in flight, flush pulsed together with a 4th accept -> rsp_valid=0 next cycle, no stale responses ever, new fetch of 0x4 returns 32'h22222222.
- load_en to word 1 with 32'hDEADBEEF at the same edge a fetch of 0x4 is accepted -> returns 32'h22222222; the next fetch of 0x4 returns 32'hDEADBEEF.
- Assert reset mid-stream -> all outputs 0, req_ready=0 during reset; memory contents retained afterward.
